// File: rtl/str_emitter.sv
// str_emitter: emits the characters of a right-justified packed string as a
// valid/ready byte stream, skipping leading NUL padding bytes.
// Optional feature: define STR_EMITTER_NUL_TERM_EN to append a trailing 8'h00
// byte (flagged with out_last) after the final character.
module str_emitter #(
    parameter int NBYTES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [8*NBYTES-1:0]          in,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic                         done,
    output logic [$clog2(NBYTES+1)-1:0]  len
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] NbytesCnt = CW'(NBYTES);

`ifdef STR_EMITTER_NUL_TERM_EN
    localparam bit NulTerm = 1'b1;
`else
    localparam bit NulTerm = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSkip,
        StEmit,
        StTerm,
        StDone
    } state_e;

    state_e              r_state;
    logic [8*NBYTES-1:0] r_sr;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_len;
    logic                r_busy;
    logic                r_out_valid;
    logic [7:0]          r_out_byte;
    logic                r_out_last;
    logic                r_done;

    logic [7:0]          w_top;
    logic [8*NBYTES-1:0] w_sr_shl;
    logic [7:0]          w_next_top;

    // Current and post-shift top bytes of the string register.
    assign w_top      = r_sr[8*NBYTES-1 -: 8];
    assign w_sr_shl   = r_sr << 8;
    assign w_next_top = w_sr_shl[8*NBYTES-1 -: 8];

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign len       = r_len;

    // Control FSM; every output is registered so it is glitch-free and holds
    // steady across consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr    <= in;
                        r_cnt   <= NbytesCnt;
                        r_len   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StSkip;
                    end
                end

                StSkip: begin
                    if (r_cnt != '0) begin
                        if (w_top != 8'h00) begin
                            // First character found; present it next cycle.
                            r_out_valid <= 1'b1;
                            r_out_byte  <= w_top;
                            r_out_last  <= !NulTerm && (r_cnt == CW'(1));
                            r_state     <= StEmit;
                        end else begin
                            r_sr  <= w_sr_shl;
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end else if (NulTerm) begin
                        r_out_valid <= 1'b1;
                        r_out_byte  <= 8'h00;
                        r_out_last  <= 1'b1;
                        r_state     <= StTerm;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end

                StEmit: begin
                    if (out_ready) begin
                        r_sr  <= w_sr_shl;
                        r_cnt <= r_cnt - CW'(1);
                        r_len <= r_len + CW'(1);
                        if (r_cnt == CW'(1)) begin
                            if (NulTerm) begin
                                r_out_byte <= 8'h00;
                                r_out_last <= 1'b1;
                                r_state    <= StTerm;
                            end else begin
                                r_out_valid <= 1'b0;
                                r_out_byte  <= 8'h00;
                                r_out_last  <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= StDone;
                            end
                        end else begin
                            // Embedded zero bytes pass through unchanged.
                            r_out_byte <= w_next_top;
                            r_out_last <= !NulTerm && (r_cnt == CW'(2));
                        end
                    end
                end

                StTerm: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StDone;
                    end
                end

                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_str_emitter.sv
// Bench for str_emitter (NBYTES=16). Expected streams are derived from the
// string itself: drop leading zero bytes, emit the rest in order, optionally
// append a NUL when STR_EMITTER_NUL_TERM_EN is defined.
module tb_str_emitter;

`ifdef STR_EMITTER_NUL_TERM_EN
    localparam int NT = 1;
`else
    localparam int NT = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] in_s;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic         out_last;
    logic         done;
    logic [4:0]   len;

    int total = 0;
    int bad   = 0;

    str_emitter #(.NBYTES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in_s),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .done      (done),
        .len       (len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_valid"}, {31'd0, out_valid}, 0);
        chk({nm, "_last"}, {31'd0, out_last}, 0);
        chk({nm, "_byte"}, {24'd0, out_byte}, 0);
        chk({nm, "_done"}, {31'd0, done}, 0);
        chk({nm, "_len"}, {27'd0, len}, 0);
    endtask

    // Runs one string; called at a negedge. mode: 0 ready high, 1 toggling,
    // 2 random. hand_len/hand_done < 0 skip the hand-computed checks.
    task automatic run_str(input logic [127:0] s, input int mode, input bit repulse,
                           input int hand_len, input int hand_done);
        logic [7:0] exp_q[$];
        logic [7:0] got_b[$];
        bit         got_l[$];
        int k, exp_len, n, first_v, done_n, dones, last_hs, post, exp_first, exp_done;
        bit prev_stall, rp_done, r;
        logic [7:0] prev_b;
        logic prev_l;

        k = 0;
        while (k < 16 && s[127-8*k -: 8] == 8'h00) k++;
        for (int i = k; i < 16; i++) exp_q.push_back(s[127-8*i -: 8]);
        exp_len = 16 - k;
        if (NT == 1) exp_q.push_back(8'h00);

        in_s  = s;
        start = 1'b1;
        n = 0; first_v = -1; done_n = -1; dones = 0; last_hs = -1; post = -1;
        prev_stall = 0; rp_done = 0; prev_b = 0; prev_l = 0;
        while (n < 300 && post != 0) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (repulse && out_valid && !rp_done) begin
                start   = 1'b1;
                rp_done = 1;
            end
            if (n == 1) chk("busy_after_start", {31'd0, busy}, 1);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 1);
                chk("stall_byte", {24'd0, out_byte}, {24'd0, prev_b});
                chk("stall_last", {31'd0, out_last}, {31'd0, prev_l});
            end
            if (out_valid && first_v < 0) first_v = n;
            case (mode)
                0:       r = 1'b1;
                1:       r = n[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (out_valid && r) begin
                got_b.push_back(out_byte);
                got_l.push_back(out_last);
                last_hs = n;
            end
            prev_stall = out_valid && !r;
            prev_b     = out_byte;
            prev_l     = out_last;
            if (done) begin
                dones++;
                if (done_n < 0) begin
                    done_n = n;
                    post   = 3;
                    chk("len_at_done", {27'd0, len}, exp_len);
                end
            end else if (post > 0) begin
                post--;
            end
        end
        out_ready = 1'b1;
        start     = 1'b0;

        if (done_n < 0) chk("done_timeout", 0, 1);
        chk("busy_after_done", {31'd0, busy}, 0);
        chk("done_pulses", dones, 1);
        chk("byte_count", got_b.size(), exp_q.size());
        for (int i = 0; i < got_b.size() && i < exp_q.size(); i++) begin
            chk($sformatf("byte[%0d]", i), {24'd0, got_b[i]}, {24'd0, exp_q[i]});
            chk($sformatf("last[%0d]", i), {31'd0, got_l[i]}, (i == exp_q.size() - 1) ? 1 : 0);
        end
        exp_first = (exp_q.size() > 0) ? 2 + k : -1;
        chk("first_valid_cycle", first_v, exp_first);
        exp_done = (last_hs >= 0) ? last_hs + 1 : 2 + k;
        if (done_n >= 0) chk("done_cycle", done_n, exp_done);
        chk("len_held", {27'd0, len}, exp_len);
        if (hand_len >= 0) chk("len_hand", {27'd0, len}, hand_len);
        if (hand_done >= 0) chk("done_hand", done_n, hand_done);
    endtask

    typedef struct {
        logic [127:0] s;
        int           mode;
        bit           rp;
        int           hl;
        int           hd;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [127:0] rs;
        int           rk;

        tbl[0].s = "FOO";              tbl[0].mode = 0; tbl[0].rp = 0;
        tbl[0].hl = 3;                 tbl[0].hd = 18 + NT;
        tbl[1].s = 128'd0;             tbl[1].mode = 0; tbl[1].rp = 0;
        tbl[1].hl = 0;                 tbl[1].hd = 18 + NT;
        tbl[2].s = "ABCDEFGHIJKLMNOP"; tbl[2].mode = 1; tbl[2].rp = 0;
        tbl[2].hl = 16;                tbl[2].hd = -1;
        tbl[3].s = "AB";               tbl[3].mode = 0; tbl[3].rp = 1;
        tbl[3].hl = 2;                 tbl[3].hd = 18 + NT;

        rst_n     = 1'b0;
        start     = 1'b0;
        in_s      = '0;
        out_ready = 1'b1;
        #1;
        chk_all_zero("reset_init");
        repeat (3) @(negedge clk);
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_str(tbl[v].s, tbl[v].mode, tbl[v].rp, tbl[v].hl, tbl[v].hd);
        end

        // Reset in the middle of emission.
        in_s  = "HELLO";
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("rst_reached_emit", {31'd0, out_valid}, 1);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_in_reset", {31'd0, done}, 0);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_str("HELLO", 0, 0, 5, 18 + NT);

        // Random strings: random padding, embedded zeros, random back-pressure.
        for (int it = 0; it < 20; it++) begin
            rs = '0;
            rk = $urandom_range(0, 16);
            for (int i = rk; i < 16; i++) begin
                if (i == rk) rs[127-8*i -: 8] = 8'($urandom_range(1, 255));
                else if ($urandom_range(0, 5) == 0) rs[127-8*i -: 8] = 8'h00;
                else rs[127-8*i -: 8] = 8'($urandom_range(0, 255));
            end
            run_str(rs, 2, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
